// File: rtl/pwd_pkg.sv
// Shared types and default limits for the pulse width decoder.
// Defaults derive from the one-shot generator's nominal pulse length so that pulse always decodes.
package pwd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMeas = 2'b01,
    StLong = 2'b10
  } pwd_state_e;

  localparam int unsigned PulseLen = 4;  // nominal one-shot generator pulse, in cycles
  localparam int unsigned DefCntW  = 8;
  localparam int unsigned DefMinW  = PulseLen / 2;
  localparam int unsigned DefMaxW  = PulseLen * 4;

endpackage

// File: rtl/pwd_edge_detect.sv
// Rise/fall detection on the measured line. Define PWD_INPUT_SYNC_EN to add a two-flop
// synchronizer ahead of the detector for inputs not synchronous to clk.
module pwd_edge_detect
  import pwd_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev_in;
  logic armed_q;
  logic arm_ok;

`ifdef PWD_INPUT_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  assign level  = sync_q[1];
  assign arm_ok = fill_q[1];  // synchronizer output is meaningless until both flops have loaded
`else
  assign level  = pulse_in;
  assign arm_ok = 1'b1;
`endif

  // A line already high at reset release is not a rise; wait for a low sample first.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_in <= 1'b0;
      armed_q <= ~pulse_in;
    end else begin
      prev_in <= level;
      if (!level && arm_ok) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign rise = level & ~prev_in & armed_q;
  assign fall = ~level & prev_in;

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of each pulse on pulse_in and reports valid / err_short / err_long
// strobes. Define PWD_INPUT_SYNC_EN to synchronize pulse_in (strobes then arrive two cycles later).
module pulse_width_decoder
  import pwd_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned MIN_W = DefMinW,
  parameter int unsigned MAX_W = DefMaxW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] width,
  output logic             valid,
  output logic             err_short,
  output logic             err_long,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_count
);

  localparam logic [CNT_W-1:0] MinW  = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] LastW = CNT_W'(MAX_W - 1);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  logic       level;
  logic       rise;
  logic       fall;
  pwd_state_e state_q;
  logic [CNT_W-1:0] cnt_q;

  pwd_edge_detect u_edge_detect (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      width       <= '0;
      valid       <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      busy        <= 1'b0;
      pulse_count <= '0;
    end else begin
      valid     <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            busy <= 1'b1;
            if (MAX_W == 1) begin
              state_q  <= StLong;
              err_long <= 1'b1;
            end else begin
              state_q <= StMeas;
              cnt_q   <= One;
            end
          end
        end
        StMeas: begin
          if (fall) begin
            width   <= cnt_q;
            state_q <= StIdle;
            busy    <= 1'b0;
            if (cnt_q >= MinW) begin
              valid       <= 1'b1;
              pulse_count <= pulse_count + One;
            end else begin
              err_short <= 1'b1;
            end
          end else if (cnt_q == LastW) begin
            // This high sample is the MAX_W-th; width keeps the last reported value.
            state_q  <= StLong;
            err_long <= 1'b1;
          end else begin
            cnt_q <= cnt_q + One;
          end
        end
        StLong: begin
          if (!level) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed self-checking bench for pulse_width_decoder with default parameters.
module tb_pulse_width_decoder;

  logic       clk;
  logic       reset;
  logic       pulse_in;
  logic [7:0] width;
  logic       valid;
  logic       err_short;
  logic       err_long;
  logic       busy;
  logic [7:0] pulse_count;

  int total;
  int bad;

  pulse_width_decoder #(
    .CNT_W (8),
    .MIN_W (2),
    .MAX_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .width       (width),
    .valid       (valid),
    .err_short   (err_short),
    .err_long    (err_long),
    .busy        (busy),
    .pulse_count (pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_width"}, 32'(width), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_short"}, 32'(err_short), 0);
    check({tag, "_long"}, 32'(err_long), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(pulse_count), 0);
  endtask

  initial begin
    int strobes;
    int widths[3];
    total = 0;
    bad   = 0;
    widths[0] = 3;
    widths[1] = 5;
    widths[2] = 2;

    // Reset with the line already high: must not count as a pulse.
    reset    = 1'b1;
    pulse_in = 1'b1;
    repeat (3) tick();
    check_idle_outputs("rst");
    reset   = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(valid) + int'(err_short) + int'(err_long) + int'(busy);
    end
    check("rst_high_ignored", 32'(strobes), 0);
    pulse_in = 1'b0;
    tick();
    check("rst_low_busy", 32'(busy), 0);

    // 4-cycle pulse -> valid, width 4.
    pulse_in = 1'b1;
    strobes  = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      strobes += int'(busy);
    end
    check("p4_busy_cycles", 32'(strobes), 4);
    check("p4_no_early_valid", 32'(valid), 0);
    pulse_in = 1'b0;
    tick();
    check("p4_valid", 32'(valid), 1);
    check("p4_width", 32'(width), 4);
    check("p4_count", 32'(pulse_count), 1);
    check("p4_busy_drop", 32'(busy), 0);
    tick();
    check("p4_valid_one_cycle", 32'(valid), 0);

    // 1-cycle pulse -> err_short, width 1.
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    tick();
    check("p1_short", 32'(err_short), 1);
    check("p1_valid", 32'(valid), 0);
    check("p1_width", 32'(width), 1);
    check("p1_count", 32'(pulse_count), 1);
    tick();
    check("p1_short_one_cycle", 32'(err_short), 0);

    // 30-cycle pulse -> err_long after the 16th high sample only.
    pulse_in = 1'b1;
    strobes  = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 15) check("p30_long_early", 32'(err_long), 0);
      if (i == 16) check("p30_long", 32'(err_long), 1);
      if (i == 17) check("p30_long_one_cycle", 32'(err_long), 0);
      if (i != 16) strobes += int'(err_long);
      strobes += int'(valid) + int'(err_short);
      if (i == 30) check("p30_busy", 32'(busy), 1);
    end
    check("p30_width_kept", 32'(width), 1);
    pulse_in = 1'b0;
    tick();
    strobes += int'(valid) + int'(err_short) + int'(err_long);
    check("p30_extra_strobes", 32'(strobes), 0);
    check("p30_busy_drop", 32'(busy), 0);
    check("p30_count", 32'(pulse_count), 1);

    // Back-to-back pulses 3, 5, 2 with one-cycle gaps, from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("b2b_count_reset", 32'(pulse_count), 0);
    for (int p = 0; p < 3; p++) begin
      pulse_in = 1'b1;
      repeat (widths[p]) tick();
      pulse_in = 1'b0;
      tick();
      check($sformatf("b2b_valid_%0d", p), 32'(valid), 1);
      check($sformatf("b2b_width_%0d", p), 32'(width), 32'(widths[p]));
    end
    check("b2b_count", 32'(pulse_count), 3);

    // Reset in cycle 3 of a 6-cycle pulse, then a clean 4-cycle pulse.
    tick();
    pulse_in = 1'b1;
    repeat (2) tick();
    check("mid_busy_before", 32'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("mid_rst");
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobes += int'(valid) + int'(err_short) + int'(err_long) + int'(busy);
    end
    pulse_in = 1'b0;
    tick();
    strobes += int'(valid) + int'(err_short) + int'(err_long) + int'(busy);
    check("mid_rest_ignored", 32'(strobes), 0);
    pulse_in = 1'b1;
    repeat (4) tick();
    pulse_in = 1'b0;
    tick();
    check("mid_after_valid", 32'(valid), 1);
    check("mid_after_width", 32'(width), 4);
    check("mid_after_count", 32'(pulse_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
- Receive-side counterpart to the team's one-shot pulse generator: measures the high time of each pulse on a single-bit input, in clk cycles.
- Classifies each pulse as valid, too short or too long, and reports the result with a one-cycle strobe.
- Sits at the far end of a one-shot-driven link, e.g. decoding pulse-width-coded commands. All logic runs in one clock domain.

Parameters:
- CNT_W, 8, width of the width counter and width output.
- MIN_W, 2, minimum accepted width in cycles. Widths below this raise err_short.
- MAX_W, 16, maximum accepted width in cycles. Reaching it while the input is still high raises err_long. Constraint: 1 <= MIN_W <= MAX_W < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- pulse_in  input  1  pulse line being measured
- width  output  CNT_W  width of the last accepted or short pulse; held until the next report
- valid  output  1  one-cycle strobe: width holds an accepted pulse (MIN_W..MAX_W-1)
- err_short  output  1  one-cycle strobe: pulse shorter than MIN_W; width holds its length
- err_long  output  1  one-cycle strobe: pulse reached MAX_W cycles high
- busy  output  1  high while in MEAS or LONG
- pulse_count  output  CNT_W  number of valid strobes since reset; wraps modulo 2**CNT_W

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, prev_in 0, cnt 0.
- Edge detection: prev_in registers pulse_in every cycle.
  - rise = pulse_in & ~prev_in
  - fall = ~pulse_in & prev_in
- Width definition: the number of clk edges at which pulse_in is sampled 1, from the rise edge inclusive.
- FSM state IDLE:
  - On rise: go to MEAS, cnt <= 1.
  - A high level without a rise (e.g. input already high when reset is released) is ignored until it goes low and rises again.
- FSM state MEAS:
  - pulse_in=1 and cnt+1 < MAX_W: cnt <= cnt+1.
  - pulse_in=1 and cnt+1 == MAX_W: go to LONG and assert err_long on the next cycle. width is not updated.
  - pulse_in=0 and cnt >= MIN_W: width <= cnt, valid=1 next cycle, pulse_count += 1, go to IDLE.
  - pulse_in=0 and cnt < MIN_W: width <= cnt, err_short=1 next cycle, go to IDLE.
- FSM state LONG:
  - Wait for pulse_in=0, then go to IDLE.
  - No further strobes, no re-measure, no restart while the input stays high.
- MAX_W == 1: the transition to LONG occurs on the rise edge itself; IDLE goes directly to LONG.
- Latency: a strobe rises one cycle after the first edge sampling pulse_in=0 (or after the MAX_W-th high sample for err_long). All strobes are exactly one cycle wide and mutually exclusive.
- busy = (state != IDLE), registered.
- Back-to-back pulses: a one-cycle low gap is legal. The low sample returns the FSM to IDLE, and the next high sample is a rise that starts a new measurement. No pulse may be lost.
- Reset mid-operation: a reset during MEAS or LONG discards the partial measurement. No strobe is emitted and all outputs clear next cycle.
- pulse_count wraps from 2**CNT_W-1 to 0 without a flag.

Optional Feature:
- Macro PWD_INPUT_SYNC_EN.
- Defined:
  - pulse_in passes through a two-flop synchronizer (reset to 0) before edge detection.
  - All strobes shift two cycles later.
  - Measured widths are unchanged.
- Undefined:
  - pulse_in is used directly; the input is required to be synchronous to clk.

Decomposition:
- Package pwd_pkg:
  - state typedef: IDLE=2'b00, MEAS=2'b01, LONG=2'b10
  - default MIN_W/MAX_W constants shared with the generator's pulse-length constant, so the generator's nominal pulse always decodes as valid.
- Sub-module pwd_edge_detect holds prev_in, produces rise/fall, and optionally contains the synchronizer under PWD_INPUT_SYNC_EN.
- FSM, counter and output registers stay in pulse_width_decoder.

Test Plan (defaults CNT_W=8, MIN_W=2, MAX_W=16):
- Reset held 3 cycles with pulse_in=1, then released -> all outputs 0, no strobe until pulse_in goes low then high; busy stays 0.
- pulse_in high exactly 4 cycles -> valid=1 for one cycle, width=4, pulse_count=1, busy high for 4 cycles; strobe one cycle after the first low sample.
- pulse_in high 1 cycle -> err_short=1 for one cycle, width=1, valid=0, pulse_count unchanged.
- pulse_in high 30 cycles -> err_long one cycle after the 16th high sample; no further strobes; busy drops one cycle after the input falls; width keeps its previous value.
- Pulses of 3, 5 and 2 cycles separated by one-cycle low gaps -> three valid strobes with widths 3, 5, 2; pulse_count=3.
- Reset asserted in cycle 3 of a 6-cycle pulse -> no strobe, outputs clear, the rest of the pulse is ignored; a following 4-cycle pulse reports width=4.
